// File: rtl/popcnt_pkg.sv
// Shared definitions for the bit-count scheduler slice.
// FSM state type, default sizes and the result-width helper.
package popcnt_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COUNT,
      ST_DONE
   } state_t;

   localparam int DEF_N_REQ  = 4;
   localparam int DEF_DATA_W = 16;

   // Width needed to hold any count from 0 up to data_w inclusive.
   function automatic int cnt_width(input int data_w);
      return $clog2(data_w + 1);
   endfunction

endpackage

// File: rtl/popcnt_sched_if.sv
// Request/result handshake bundle between requesters,
// the popcount scheduler and the result consumer.
interface popcnt_sched_if
   import popcnt_pkg::*;
#(
   parameter int N_REQ  = DEF_N_REQ,
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = cnt_width(DATA_W),
   parameter int ID_W   = $clog2(N_REQ)
);

   logic [N_REQ-1:0]        req_valid;
   logic [N_REQ*DATA_W-1:0] req_data;
   logic [N_REQ-1:0]        req_ready;
   logic                    res_valid;
   logic                    res_ready;
   logic [CNT_W-1:0]        res_count;
   logic [ID_W-1:0]         res_id;
   logic                    busy;

   modport master (
      output req_valid,
      output req_data,
      input  req_ready,
      input  res_valid,
      output res_ready,
      input  res_count,
      input  res_id,
      input  busy
   );

   modport slave (
      input  req_valid,
      input  req_data,
      output req_ready,
      output res_valid,
      input  res_ready,
      output res_count,
      output res_id,
      output busy
   );

endinterface

// File: rtl/popcount_serial.sv
// Bit-serial ones counter: consumes one bit per clock,
// pulses done on the cycle the last bit is accumulated.
module popcount_serial
   import popcnt_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = cnt_width(DATA_W)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] load_data,
   output logic              done,
   output logic [CNT_W-1:0]  count
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

   logic [DATA_W-1:0] shift_q;
   logic [CNT_W-1:0]  acc_q;
   logic [CNT_W-1:0]  idx_q;
   logic              active_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         shift_q  <= '0;
         acc_q    <= '0;
         idx_q    <= '0;
         active_q <= 1'b0;
      end else if (start) begin
         shift_q  <= load_data;
         acc_q    <= '0;
         idx_q    <= '0;
         active_q <= 1'b1;
      end else if (active_q) begin
         acc_q   <= acc_q + CNT_W'(shift_q[0]);
         shift_q <= shift_q >> 1;
         idx_q   <= idx_q + CNT_W'(1);
         if (idx_q == LAST) begin
            active_q <= 1'b0;
         end
      end
   end

   assign done  = active_q && (idx_q == LAST);
   assign count = acc_q;

endmodule

// File: rtl/popcnt_sched.sv
// Round-robin scheduler sharing one serial popcount engine
// between N_REQ requesters; returns count tagged with requester id.
module popcnt_sched
   import popcnt_pkg::*;
#(
   parameter int N_REQ  = DEF_N_REQ,
   parameter int DATA_W = DEF_DATA_W,
   parameter int CNT_W  = cnt_width(DATA_W),
   parameter int ID_W   = $clog2(N_REQ)
) (
   input logic           clk,
   input logic           reset,
   popcnt_sched_if.slave bus
);

   state_t            state_q, state_n;
   logic [ID_W-1:0]   ptr_q, ptr_n;
   logic [ID_W-1:0]   win;
   logic [ID_W-1:0]   res_id_q;
   logic [ID_W:0]     sum;
   logic              found;
   logic              start;
   logic              done;
   logic [DATA_W-1:0] load;
   logic [CNT_W-1:0]  count;

   // Search upward from ptr, wrapping modulo N_REQ.
   always_comb begin
      found = 1'b0;
      win   = '0;
      sum   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         sum = {1'b0, ptr_q} + (ID_W+1)'(i);
         if (sum >= (ID_W+1)'(N_REQ)) begin
            sum = sum - (ID_W+1)'(N_REQ);
         end
         if (!found && bus.req_valid[sum[ID_W-1:0]]) begin
            found = 1'b1;
            win   = sum[ID_W-1:0];
         end
      end
   end

   always_comb begin
      load = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win == ID_W'(i)) begin
            load = bus.req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   assign ptr_n = (win == ID_W'(N_REQ - 1)) ? '0 : win + ID_W'(1);

   always_comb begin
      state_n = state_q;
      start   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (found && !reset) begin
               start   = 1'b1;
               state_n = ST_COUNT;
            end
         end
         ST_COUNT: begin
            if (done) begin
               state_n = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.res_ready) begin
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         ptr_q    <= '0;
         res_id_q <= '0;
      end else begin
         state_q <= state_n;
         if (start) begin
            ptr_q    <= ptr_n;
            res_id_q <= win;
         end
      end
   end

   popcount_serial #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_engine (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .load_data (load),
      .done      (done),
      .count     (count)
   );

   assign bus.req_ready = start ? (N_REQ'(1) << win) : '0;
   assign bus.res_valid = (state_q == ST_DONE);
   assign bus.busy      = (state_q != ST_IDLE);
   assign bus.res_count = count;
   assign bus.res_id    = res_id_q;

endmodule

// File: doc/popcnt_sched.md
# popcnt_sched

Round-robin scheduler that shares one bit-serial population-count engine (one input bit per clock) between `N_REQ` requesters. Each requester presents a `DATA_W`-bit word on a valid/ready handshake. The scheduler grants one requester, feeds its word through the serial counter, and returns the ones-count tagged with the requester index on a result valid/ready handshake. It sits between the requester front-ends and any consumer of bit-count results.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters; must be ≥ 2.
- `DATA_W`, default 16: word width.
- `CNT_W`, default `$clog2(DATA_W+1)` = 5: result width. It must hold the value `DATA_W`.
- `ID_W`, default `$clog2(N_REQ)` = 2: requester-index width.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in `N_REQ`: per-requester request valid.
- `req_data` in `N_REQ*DATA_W`: requester *i* uses bits `[i*DATA_W +: DATA_W]`.
- `req_ready` out `N_REQ`: one-hot grant/accept, or zero.
- `res_valid` out 1: result available.
- `res_ready` in 1: consumer accepts result.
- `res_count` out `CNT_W`: number of 1s in the granted word.
- `res_id` out `ID_W`: index of the granted requester.
- `busy` out 1: high in COUNT and DONE.

## Operation
- **States:** IDLE, COUNT, DONE. Reset enters IDLE.
- **IDLE:**
  - `req_ready[g]` = 1 only for the arbitration winner *g*; this is combinational from `req_valid` and the RR pointer.
  - Winner: the first asserted `req_valid` found searching from `ptr` upward, wrapping modulo `N_REQ`.
  - No `req_valid` asserted: `req_ready` = 0 and the FSM stays in IDLE.
- **Accept (IDLE, `req_valid[g]`):**
  - Latch `req_data` slice *g* into the shift register.
  - Latch *g* into `res_id`.
  - Clear the accumulator and bit index.
  - Set `ptr` = (*g*+1) mod `N_REQ`.
  - Go to COUNT.
- **COUNT:**
  - Each cycle, accumulator += shift_reg[0], then shift right by 1 and increment the index.
  - After exactly `DATA_W` bits, go to DONE.
  - `req_ready` = 0 throughout.
- **DONE:**
  - `res_valid` = 1 and `res_count` = accumulator, both held stable until `res_ready` = 1.
  - On handshake, go to IDLE. `res_count` and `res_id` keep their values, but are meaningful only while `res_valid` = 1.
- **Requester obligations:** hold `req_valid` and the data slice stable until `req_ready` is seen. Dropping `req_valid` before grant is legal; the winner is re-evaluated each IDLE cycle.
- **Arithmetic:**
  - The accumulator is `CNT_W` bits unsigned and never wraps; the maximum is `DATA_W`.
  - All-ones input yields `DATA_W` (16 → 5'b10000). All-zeros yields 0.
- **Simultaneous events:**
  - A new `req_valid` arriving during COUNT or DONE is not accepted; it waits for IDLE.
  - `res_ready` and a pending request in the same DONE cycle: the result completes, and the request is granted in the following IDLE cycle.
- **Reset, at any time including mid-COUNT or DONE:**
  - Aborts the job and discards the partial count; no `res_valid` pulse is produced.
  - Sets `ptr` = 0.

## Timing
- **Reset values:**
  - `req_ready` = 0, `res_valid` = 0, `res_count` = 0, `res_id` = 0, `busy` = 0.
  - state = IDLE, `ptr` = 0.
- **Latency:** accept at edge E0; bits are counted on edges E1..E`DATA_W`. `res_valid` rises after edge E`DATA_W`, i.e. `DATA_W` cycles after acceptance.
- **Throughput:** with `res_ready` tied high, one job per `DATA_W`+2 cycles (1 IDLE + `DATA_W` COUNT + 1 DONE).
- **Outputs:**
  - `req_ready` is combinational in IDLE only.
  - `res_valid`, `res_count`, `res_id` and `busy` are registered or state-decoded, with no combinational path from the `req_*` inputs.

## Structure
- **Shared package `popcnt_pkg`:**
  - The state enum (IDLE/COUNT/DONE).
  - Default `DATA_W`/`N_REQ` constants.
  - A `CNT_W` helper function, so all bit-count blocks size results consistently.
- **Sub-module `popcount_serial`:**
  - Contents: shift register, bit index and accumulator.
  - Interface: `start`/`load_data` in, `done`/`count` out.
  - It counts exactly `DATA_W` bits, then raises `done` for one cycle.
- **Top level:** `popcnt_sched` holds the FSM, round-robin pointer, grant logic and result registers.

## Test plan
1. **Reset, single job:** reset 2 cycles, then `req_valid` = 4'b0001 with data 16'hA5A5.
   - `req_ready` = 4'b0001 for one cycle.
   - 16 cycles later `res_valid` = 1, `res_count` = 8, `res_id` = 0.
2. **Extremes:** data 16'hFFFF, then 16'h0000.
   - `res_count` = 16 (5'b10000), then 0; no overflow.
3. **Round robin:** all four `req_valid` held high, `res_ready` = 1.
   - Grants in order 0,1,2,3,0.
   - Each `res_id` matches its grant; consecutive accepts are 18 cycles apart.
4. **Backpressure:** `res_ready` = 0 for 10 cycles after `res_valid`.
   - `res_valid`, `res_count` and `res_id` stay stable; no `req_ready` while stalled.
   - Grant resumes on the first IDLE cycle after `res_ready`.
5. **Reset mid-operation:** assert `reset` during cycle 8 of COUNT.
   - All outputs go to reset values on the next edge and no `res_valid` appears.
   - The next request from requester 2 alone gets `req_ready` = 4'b0100.
6. **Random self-check:** 200 random words on random requesters.
   - Each `res_count` equals the reference bit count of the accepted word.
   - `res_id` equals the granting index.
